// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t : fetch FSM states (IDLE, REQ, WAIT, HOLD)
//   OP_HI / OP_LO : bit range of the opcode field inside an instruction word
//   PC_INC        : byte increment between sequential instruction words
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } fetch_state_t;

    localparam int unsigned OP_HI  = 31;
    localparam int unsigned OP_LO  = 26;
    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter register for the fetch unit.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   redirect         : branch/jump redirect pulse (highest priority)
//   redirect_target  : redirect byte address; low two bits are masked off
//   advance          : sequential advance after a captured response
//   advance_base     : address of the captured word; PC becomes base + PC_INC
//   pc               : current fetch address (always word-aligned)
//   misalign         : sticky flag, set when a redirect target was unaligned
module pc_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              advance,
    input  logic [ADDR_W-1:0] advance_base,
    output logic [ADDR_W-1:0] pc,
    output logic              misalign
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            misalign <= 1'b0;
        end else if (redirect) begin
            pc <= {redirect_target[ADDR_W-1:2], 2'b00};
            if (redirect_target[1:0] != 2'b00) begin
                misalign <= 1'b1;
            end
        end else if (advance) begin
            // Natural modulo-2^ADDR_W wrap at the top of the address space.
            pc <= advance_base + ADDR_W'(PC_INC);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage feeding the decoder.
// Ports:
//   CLK, RSTN              : clock, asynchronous active-low reset
//   IMEM_REQ/ADDR/GNT      : request/grant handshake to instruction memory
//   IMEM_RVALID/RDATA      : response from instruction memory
//   INSTR_VALID/READY      : valid/ready hold register toward the decoder
//   INSTR, OP, PC_OUT      : fetched word, its opcode field and its address
//   BR_TAKEN/BR_TARGET     : redirect from execute
//   MISALIGN               : sticky unaligned-redirect flag
//   FETCH_CNT              : count of instructions consumed by the decoder
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               RSTN,
    output logic               IMEM_REQ,
    output logic [ADDR_W-1:0]  IMEM_ADDR,
    input  logic               IMEM_GNT,
    input  logic               IMEM_RVALID,
    input  logic [INSTR_W-1:0] IMEM_RDATA,
    output logic               INSTR_VALID,
    input  logic               INSTR_READY,
    output logic [INSTR_W-1:0] INSTR,
    output logic [5:0]         OP,
    output logic [ADDR_W-1:0]  PC_OUT,
    input  logic               BR_TAKEN,
    input  logic [ADDR_W-1:0]  BR_TARGET,
    output logic               MISALIGN,
    output logic [31:0]        FETCH_CNT
);

    fetch_state_t      state;
    logic              discard;
    logic [ADDR_W-1:0] faddr;
    logic [ADDR_W-1:0] pc;
    logic              capture;

    // A response is accepted only in WAIT, when it is not stale and no
    // redirect arrives in the same cycle.
    assign capture = (state == ST_WAIT) && IMEM_RVALID && !discard && !BR_TAKEN;

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk             (CLK),
        .rst_n           (RSTN),
        .redirect        (BR_TAKEN),
        .redirect_target (BR_TARGET),
        .advance         (capture),
        .advance_base    (faddr),
        .pc              (pc),
        .misalign        (MISALIGN)
    );

    assign IMEM_ADDR = pc;
    assign OP        = INSTR[OP_HI:OP_LO];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= ST_IDLE;
            IMEM_REQ    <= 1'b0;
            discard     <= 1'b0;
            faddr       <= '0;
            INSTR_VALID <= 1'b0;
            INSTR       <= '0;
            PC_OUT      <= '0;
            FETCH_CNT   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_REQ;
                    IMEM_REQ <= 1'b1;
                end
                ST_REQ: begin
                    if (IMEM_GNT) begin
                        // The old address is already accepted; a same-cycle
                        // redirect marks its response as stale.
                        faddr    <= pc;
                        discard  <= BR_TAKEN;
                        state    <= ST_WAIT;
                        IMEM_REQ <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (BR_TAKEN) begin
                        if (IMEM_RVALID) begin
                            discard  <= 1'b0;
                            state    <= ST_REQ;
                            IMEM_REQ <= 1'b1;
                        end else begin
                            discard <= 1'b1;
                        end
                    end else if (IMEM_RVALID) begin
                        if (discard) begin
                            discard  <= 1'b0;
                            state    <= ST_REQ;
                            IMEM_REQ <= 1'b1;
                        end else begin
                            INSTR       <= IMEM_RDATA;
                            PC_OUT      <= faddr;
                            INSTR_VALID <= 1'b1;
                            state       <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (BR_TAKEN) begin
                        INSTR_VALID <= 1'b0;
                        state       <= ST_REQ;
                        IMEM_REQ    <= 1'b1;
                    end else if (INSTR_READY) begin
                        INSTR_VALID <= 1'b0;
                        FETCH_CNT   <= FETCH_CNT + 32'd1;
                        state       <= ST_REQ;
                        IMEM_REQ    <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    IMEM_REQ <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit. The reference model tracks
// the architectural program flow: the address the next consumed instruction
// must come from, the consume count and the sticky misalign flag.
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        RSTN;
    always #5 CLK = ~CLK;

    logic        IMEM_REQ, IMEM_GNT, IMEM_RVALID, INSTR_VALID, INSTR_READY;
    logic        BR_TAKEN, MISALIGN;
    logic [31:0] IMEM_ADDR, IMEM_RDATA, INSTR, PC_OUT, BR_TARGET, FETCH_CNT;
    logic [5:0]  OP;

    logic        req2, gnt2, rv2, valid2, ready2, br2, mis2;
    logic [31:0] addr2, rdata2, instr2, pc2, target2, cnt2;
    logic [5:0]  op2;

    instruction_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .RSTN(RSTN), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_GNT(IMEM_GNT), .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .INSTR(INSTR),
        .OP(OP), .PC_OUT(PC_OUT), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
        .MISALIGN(MISALIGN), .FETCH_CNT(FETCH_CNT)
    );

    instruction_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .CLK(CLK), .RSTN(RSTN), .IMEM_REQ(req2), .IMEM_ADDR(addr2),
        .IMEM_GNT(gnt2), .IMEM_RVALID(rv2), .IMEM_RDATA(rdata2),
        .INSTR_VALID(valid2), .INSTR_READY(ready2), .INSTR(instr2),
        .OP(op2), .PC_OUT(pc2), .BR_TAKEN(br2), .BR_TARGET(target2),
        .MISALIGN(mis2), .FETCH_CNT(cnt2)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic        pending;
    logic        m_mis;
    int          m_cnt;
    int          idle_cycles;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h2001_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc      = 32'h0;
        pending     = 1'b0;
        m_mis       = 1'b0;
        m_cnt       = 0;
        idle_cycles = 0;
    endtask

    // One clock cycle on the main DUT: drive inputs, advance the model, check.
    task automatic cyc(input logic g, input logic rv, input logic rdy,
                       input logic b, input logic [31:0] t);
        logic        p_req, p_valid, fire_gnt, fire_rsp, consume;
        logic [31:0] p_addr, p_instr, p_pc, d;
        IMEM_GNT    = g;
        IMEM_RVALID = rv;
        IMEM_RDATA  = (rv && pending) ? mem(pend_addr) : (32'hBAD0_BAD0 ^ $urandom);
        INSTR_READY = rdy;
        BR_TAKEN    = b;
        BR_TARGET   = t;
        p_req   = IMEM_REQ;
        p_addr  = IMEM_ADDR;
        p_valid = INSTR_VALID;
        p_instr = INSTR;
        p_pc    = PC_OUT;
        fire_gnt = p_req && g;
        fire_rsp = pending && rv;
        consume  = p_valid && rdy && !b;
        @(posedge CLK);
        #1;
        if (fire_rsp) pending = 1'b0;
        if (fire_gnt) begin
            pending   = 1'b1;
            pend_addr = p_addr;
        end
        if (consume) begin
            exp_pc      = exp_pc + 32'd4;
            m_cnt       = m_cnt + 1;
            idle_cycles = 0;
        end else begin
            idle_cycles = idle_cycles + 1;
        end
        if (b) begin
            exp_pc = {t[31:2], 2'b00};
            if (t[1:0] != 2'b00) m_mis = 1'b1;
        end

        chk("fetch_cnt", FETCH_CNT, m_cnt);
        chk("misalign", MISALIGN, m_mis);
        chk("addr_align", IMEM_ADDR[1:0], 2'b00);
        if (pending) chk("one_outstanding", IMEM_REQ, 1'b0);
        if (INSTR_VALID) begin
            d = mem(exp_pc);
            chk("pc_out", PC_OUT, exp_pc);
            chk("instr", INSTR, d);
            chk("op", OP, d[31:26]);
        end
        if (p_req && !g && !b) begin
            chk("req_stable", IMEM_REQ, 1'b1);
            chk("addr_stable", IMEM_ADDR, p_addr);
        end
        if (p_valid && !rdy && !b) begin
            chk("hold_valid", INSTR_VALID, 1'b1);
            chk("hold_instr", INSTR, p_instr);
            chk("hold_pc", PC_OUT, p_pc);
        end
        if (p_valid && (rdy || b)) begin
            chk("release_valid", INSTR_VALID, 1'b0);
            chk("release_req", IMEM_REQ, 1'b1);
        end
        if (idle_cycles > 200) begin
            tests++;
            fails++;
            $error("FAIL progress_timeout: observed %0d idle cycles required at most 200", idle_cycles);
            idle_cycles = 0;
        end
    endtask

    initial begin
        RSTN = 1'b0;
        IMEM_GNT = 0; IMEM_RVALID = 0; IMEM_RDATA = 0; INSTR_READY = 0;
        BR_TAKEN = 0; BR_TARGET = 0;
        gnt2 = 0; rv2 = 0; rdata2 = 0; ready2 = 0; br2 = 0; target2 = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_req", IMEM_REQ, 1'b0);
        chk("rst_valid", INSTR_VALID, 1'b0);
        chk("rst_instr", INSTR, 32'h0);
        chk("rst_pc_out", PC_OUT, 32'h0);
        chk("rst_mis", MISALIGN, 1'b0);
        chk("rst_cnt", FETCH_CNT, 32'h0);
        chk("rst_addr", IMEM_ADDR, 32'h0);
        chk("rst_addr_wrap", addr2, 32'hFFFF_FFFC);
        RSTN = 1'b1;

        // IDLE -> REQ
        cyc(0, 0, 0, 0, 0);
        chk("t1_req", IMEM_REQ, 1'b1);
        chk("t1_addr", IMEM_ADDR, 32'h0);
        // zero-wait memory: valid two cycles after REQ
        cyc(1, 0, 0, 0, 0);
        chk("t1_valid_early", INSTR_VALID, 1'b0);
        chk("t1_req_wait", IMEM_REQ, 1'b0);
        cyc(0, 1, 0, 0, 0);
        chk("t1_valid", INSTR_VALID, 1'b1);
        chk("t1_instr", INSTR, 32'h2001_0005);
        chk("t1_op", OP, 6'b001000);
        chk("t1_pc_out", PC_OUT, 32'h0);
        cyc(0, 0, 1, 0, 0);
        chk("t1_next_addr", IMEM_ADDR, 32'h4);
        chk("t1_cnt", FETCH_CNT, 32'd1);

        // delayed grant and response
        repeat (3) begin
            cyc(0, 0, 0, 0, 0);
            chk("t2_req", IMEM_REQ, 1'b1);
            chk("t2_addr", IMEM_ADDR, 32'h4);
        end
        cyc(1, 0, 0, 0, 0);
        repeat (2) begin
            cyc(0, 0, 0, 0, 0);
            chk("t2_wait_valid", INSTR_VALID, 1'b0);
        end
        cyc(0, 1, 0, 0, 0);
        chk("t2_valid", INSTR_VALID, 1'b1);
        chk("t2_pc_out", PC_OUT, 32'h4);
        cyc(0, 0, 1, 0, 0);
        chk("t2_cnt", FETCH_CNT, 32'd2);

        // decoder stall in HOLD
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        repeat (5) begin
            cyc(0, 0, 0, 0, 0);
            chk("t3_instr", INSTR, mem(32'h8));
            chk("t3_pc_out", PC_OUT, 32'h8);
            chk("t3_req", IMEM_REQ, 1'b0);
            chk("t3_cnt", FETCH_CNT, 32'd2);
        end
        cyc(0, 0, 1, 0, 0);
        chk("t3_valid_drop", INSTR_VALID, 1'b0);
        chk("t3_cnt_inc", FETCH_CNT, 32'd3);

        // redirect while waiting for the response
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h100);
        cyc(0, 1, 0, 0, 0);
        chk("t4_dropped", INSTR_VALID, 1'b0);
        chk("t4_addr", IMEM_ADDR, 32'h100);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("t4_pc_out", PC_OUT, 32'h100);
        chk("t4_instr", INSTR, mem(32'h100));
        cyc(0, 0, 1, 0, 0);

        // unaligned redirect coinciding with grant
        cyc(1, 0, 0, 1, 32'h202);
        chk("t5_mis", MISALIGN, 1'b1);
        cyc(0, 1, 0, 0, 0);
        chk("t5_dropped", INSTR_VALID, 1'b0);
        chk("t5_addr", IMEM_ADDR, 32'h200);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("t5_pc_out", PC_OUT, 32'h200);
        // redirect in HOLD beats a same-cycle consume
        cyc(0, 0, 1, 1, 32'h300);
        chk("t6_cnt", FETCH_CNT, 32'd4);
        chk("t6_valid", INSTR_VALID, 1'b0);
        chk("t6_addr", IMEM_ADDR, 32'h300);
        chk("t6_mis_sticky", MISALIGN, 1'b1);
        // redirect coinciding with the response
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 32'h400);
        chk("t7_valid", INSTR_VALID, 1'b0);
        chk("t7_addr", IMEM_ADDR, 32'h400);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom % 3) == 0,
                pending ? (($urandom % 3) == 0) : (($urandom % 8) == 0),
                ($urandom % 2) == 0,
                ($urandom % 25) == 0,
                $urandom);
        end

        // reset asserted mid-transaction
        for (int i = 0; i < 40; i++) begin
            if (pending) break;
            cyc(1, 0, 1, 0, 0);
        end
        chk("r_in_wait", IMEM_REQ, 1'b0);
        IMEM_RVALID = 1'b1;
        RSTN = 1'b0;
        #1;
        chk("r_req", IMEM_REQ, 1'b0);
        chk("r_valid", INSTR_VALID, 1'b0);
        chk("r_instr", INSTR, 32'h0);
        chk("r_pc_out", PC_OUT, 32'h0);
        chk("r_mis", MISALIGN, 1'b0);
        chk("r_cnt", FETCH_CNT, 32'h0);
        chk("r_addr", IMEM_ADDR, 32'h0);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        model_reset();
        cyc(0, 1, 0, 0, 0);
        chk("r_idle_ignore", INSTR_VALID, 1'b0);
        chk("r_req_up", IMEM_REQ, 1'b1);
        cyc(0, 1, 0, 0, 0);
        chk("r_req_ignore", INSTR_VALID, 1'b0);
        chk("r_addr_restart", IMEM_ADDR, 32'h0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("r_instr_after", INSTR, 32'h2001_0005);
        chk("r_pc_after", PC_OUT, 32'h0);
        cyc(0, 0, 1, 0, 0);

        // PC wrap at the top of the address space
        chk("w_addr", addr2, 32'hFFFF_FFFC);
        chk("w_req", req2, 1'b1);
        gnt2 = 1'b1;
        @(posedge CLK); #1;
        gnt2 = 1'b0; rv2 = 1'b1; rdata2 = 32'h1234_5678;
        @(posedge CLK); #1;
        rv2 = 1'b0;
        chk("w_valid", valid2, 1'b1);
        chk("w_pc_out", pc2, 32'hFFFF_FFFC);
        chk("w_instr", instr2, 32'h1234_5678);
        ready2 = 1'b1;
        @(posedge CLK); #1;
        ready2 = 1'b0;
        chk("w_next_req", req2, 1'b1);
        chk("w_next_addr", addr2, 32'h0);
        chk("w_cnt", cnt2, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the instruction decoder. Owns the program counter and issues one word fetch at a time to instruction memory using a request/grant/response handshake. Presents the fetched instruction, its PC and the 6-bit opcode field to the decoder through a valid/ready hold register. Accepts branch/jump redirects from the execute path and discards stale in-flight data.

Parameters:
ADDR_W, 32, PC and memory address width in bits (byte address)
INSTR_W, 32, instruction width in bits
RESET_PC, 0, PC value loaded on reset; must be word-aligned

Ports:
CLK  in  1  single clock, rising edge
RSTN  in  1  reset, asynchronous assert, active-low
IMEM_REQ  out  1  fetch request valid
IMEM_ADDR  out  ADDR_W  fetch byte address, word-aligned
IMEM_GNT  in  1  memory accepts the request this cycle
IMEM_RVALID  in  1  response data valid
IMEM_RDATA  in  INSTR_W  response instruction word
INSTR_VALID  out  1  INSTR, PC_OUT and OP are valid
INSTR_READY  in  1  decoder consumes the current instruction
INSTR  out  INSTR_W  fetched instruction
OP  out  6  INSTR[31:26], drives the decoder opcode input
PC_OUT  out  ADDR_W  address of INSTR
BR_TAKEN  in  1  redirect pulse from execute
BR_TARGET  in  ADDR_W  redirect byte address
MISALIGN  out  1  sticky flag: a redirect target had nonzero [1:0]
FETCH_CNT  out  32  count of instructions consumed (VALID & READY), wraps

Behaviour:
- Reset, asynchronous on RSTN low: PC=RESET_PC, state=IDLE, INSTR_VALID=0, INSTR=0, PC_OUT=0, DISCARD=0, MISALIGN=0, FETCH_CNT=0. IMEM_REQ=0 while in reset and in IDLE.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: go to REQ on the first edge after reset release. IDLE is not re-entered.
- REQ: IMEM_REQ=1 and IMEM_ADDR=PC. Both hold stable until IMEM_GNT. On GNT, latch FADDR=PC and go to WAIT.
- WAIT: IMEM_REQ=0. On IMEM_RVALID:
  - DISCARD=1: clear DISCARD, drop the data, go to REQ.
  - DISCARD=0: INSTR<=IMEM_RDATA, PC_OUT<=FADDR, INSTR_VALID<=1, PC<=FADDR+4 (modulo 2^ADDR_W, so it wraps at the top), go to HOLD.
- HOLD: INSTR, PC_OUT and OP stay stable while INSTR_VALID=1. When INSTR_READY=1: INSTR_VALID<=0, FETCH_CNT increments, go to REQ.
- Throughput: at most one instruction per 3 cycles with zero-wait memory. Latency from entering REQ to INSTR_VALID is 2 cycles when GNT and RVALID each arrive on their first possible cycle.
- One outstanding request only. RVALID seen outside WAIT is ignored.
- Redirect (BR_TAKEN=1) always sets PC<=BR_TARGET with [1:0] forced to 00. If BR_TARGET[1:0]!=0, MISALIGN<=1 (sticky until reset). Then, by state:
  - REQ without GNT: stay in REQ; IMEM_ADDR shows the new PC next cycle.
  - REQ with GNT in the same cycle: the old address was accepted, so go to WAIT with DISCARD=1.
  - WAIT without RVALID: DISCARD<=1.
  - WAIT with RVALID in the same cycle: drop the data and go to REQ.
  - HOLD: INSTR_VALID<=0 and go to REQ. FETCH_CNT does not increment, even if INSTR_READY=1 in that cycle.
- Redirect takes priority over consume and over response capture in the same cycle.
- Reset asserted mid-transaction returns everything to the reset values. A response arriving after reset release while in IDLE or REQ is ignored.

Decomposition:
- Shared package: fetch FSM state encoding (IDLE/REQ/WAIT/HOLD), OP field position constants (OP_HI=31, OP_LO=26), and a PC_INC=4 constant.
- One natural sub-module: pc_register. It holds the PC, applies redirect and increment, does alignment masking, and generates MISALIGN.
- The FSM, hold register and counter stay in the top module.

Test Plan:
- Reset then zero-wait memory returning 0x20010005 at address 0: IMEM_ADDR=0x0; INSTR_VALID rises 2 cycles after REQ; OP=6'b001000; PC_OUT=0; next request address is 0x4.
- GNT delayed 3 cycles, then RVALID delayed 2 cycles: IMEM_REQ and IMEM_ADDR stay stable throughout; exactly one instruction delivered; FETCH_CNT=1 after READY.
- INSTR_READY held low for 5 cycles in HOLD: INSTR and PC_OUT unchanged, IMEM_REQ=0, FETCH_CNT unchanged; READY=1 gives VALID=0 next cycle and FETCH_CNT+1.
- BR_TAKEN with target 0x100 while in WAIT: the pending response is dropped and never appears on INSTR; the next IMEM_ADDR is 0x100; the delivered instruction has PC_OUT=0x100.
- BR_TAKEN with target 0x202 in the same cycle as GNT: IMEM_ADDR is 0x200 on the following request; MISALIGN=1 and stays 1; the old response is discarded.
- RESET_PC=0xFFFFFFFC: after one fetch, the next IMEM_ADDR is 0x0 (wrap). RSTN pulsed low during WAIT: all outputs return to reset values immediately and fetch restarts at RESET_PC.
